// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential BCD-to-binary converter using reverse double-dabble.
// Each clock in CONV shifts the {bcd, bin} register right by one bit and then
// subtracts 3 from every BCD digit field that reads 8 or more. After BIN_W
// iterations the binary part holds the result and the BCD part is empty.
module bcd_to_binary #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   d,
    output logic [BIN_W-1:0]      b,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [SR_W-1:0]    sr_iter;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   b_d;
    logic               done_d;
    logic               err_d;
    logic               d_invalid;

    // Flag an operand that contains any digit above 9.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        d_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d[4*i +: 4] > 4'd9) begin
                d_invalid = 1'b1;
            end
        end
    end

    // One reverse double-dabble step: shift right, then correct each BCD digit >= 8.
    always_comb begin
        sr_iter = sr_q >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_iter[BIN_W + 4*i +: 4] >= 4'd8) begin
                sr_iter[BIN_W + 4*i +: 4] = sr_iter[BIN_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and datapath decisions for the IDLE/CONV handshake.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        b_d     = b;
        done_d  = 1'b0;
        err_d   = err;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (d_invalid) begin
                        // Rejected request: report it without touching B or entering CONV.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        sr_d    = {d, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                sr_d  = sr_iter;
                cnt_d = cnt_q + 1'b1;
                // This edge performs the final iteration; publish the binary part.
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    b_d     = sr_iter[BIN_W-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            b       <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            b       <= b_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    assign busy = (state_q == CONV);

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential BCD-to-binary converter: the inverse of the calculator's binary-to-BCD path.
- Accepts a packed multi-digit BCD value from the keypad/digit-entry side and produces the unsigned binary value for the adder datapath.
- Uses iterative reverse double-dabble (shift-right, subtract-3 correction), one iteration per clock, with a START/BUSY/DONE handshake.

Parameters:
- DIGITS, 2, number of packed BCD digits; digit 0 sits in D[3:0].
- BIN_W, 7, binary result width and iteration count; must satisfy 2^BIN_W >= 10^DIGITS.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  conversion request; sampled only in IDLE.
- D  input  4*DIGITS  packed BCD operand; sampled on the edge that accepts START.
- B  output  BIN_W  binary result register.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse: result or error is available.
- ERR  output  1  high if the last accepted request contained a digit greater than 9.

Behaviour:
- Reset (asynchronous, RST=1): state=IDLE, B=0, BUSY=0, DONE=0, ERR=0, iteration counter=0, shift register=0. Reset mid-conversion abandons the conversion; no DONE is produced.
- Internal shift register SR is (4*DIGITS + BIN_W) bits = {bcd_part, bin_part}.
- States: IDLE, CONV.
- IDLE, START=1, all digits <=9, at edge k:
  - SR <= {D, 0}, counter <= 0, ERR <= 0, state -> CONV, BUSY -> 1.
- IDLE, START=1, any digit >9, at edge k:
  - no conversion; ERR <= 1, DONE <= 1 for one cycle, B unchanged, BUSY stays 0, state stays IDLE.
- CONV, each edge:
  - SR shifted right by 1 (zero fill at MSB).
  - Then every 4-bit digit field of bcd_part that is >=8 has 3 subtracted, all fields in parallel, same cycle.
  - counter increments.
- On the edge completing iteration BIN_W (edge k+BIN_W):
  - B <= bin_part after that iteration, DONE <= 1, BUSY <= 0, state -> IDLE.
  - bcd_part is all zero for any valid input.
- Latency: DONE high during the cycle after edge k+BIN_W (7 cycles for the defaults). DONE deasserts at the following edge unless a new error pulse is issued on that edge.
- START while BUSY=1 is ignored and not queued. D changes during CONV have no effect.
- Back-to-back operation: START may be asserted in the DONE cycle (state is IDLE) and is accepted on that edge.
- B holds its value until the next successful completion. ERR holds until the next accepted START.
- Arithmetic is unsigned; no overflow is possible given the BIN_W constraint.

Test Plan:
- Defaults; D=8'h00, START pulse -> BUSY high 7 cycles; DONE pulse at edge k+7; B=7'd0, ERR=0.
- D=8'h99 -> B=7'd99 (7'h63); D=8'h47 -> B=7'd47 (7'h2F); sweep all 100 valid codes 8'h00-8'h99 -> B equals the decimal value each time.
- D=8'h3A, START -> ERR=1 and DONE=1 in the cycle after the edge; BUSY never rises; B retains the prior value (e.g. 99); next valid START clears ERR.
- START with D=8'h12, then START held high with D=8'h34 during BUSY -> single DONE, B=7'd12; START reasserted in the DONE cycle -> accepted, next result B=7'd34.
- Assert RST asynchronously at iteration 3 of D=8'h56 -> B, BUSY, DONE, ERR go 0 immediately without a clock edge; no DONE after release; a fresh START converts 8'h56 -> 7'd56.
- DIGITS=3, BIN_W=10: D=12'h999 -> B=10'd999 after 10 iterations.
